// File: rtl/read_arb_pkg.sv
// Shared definitions for the AXI4 read-port arbiter: requester ids and limits.
package read_arb_pkg;

  localparam int unsigned C_MAX_REQ = 4;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_NFA   = 2'd0;
  localparam req_id_t REQ_QUERY = 2'd1;

endpackage

// File: rtl/read_port_arbiter_tag_fifo.sv
// In-order FIFO of granted requester ids; the head selects where R beats go.
module tag_fifo
  import read_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  req_id_t       mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/read_port_arbiter.sv
// Round-robin sharing of one AXI4 read master port among C_NUM_REQ requesters.
// Optional READ_ARB_PERF_CNT_EN adds per-requester R-beat counters (perf_beats/perf_clr).
module read_port_arbiter
  import read_arb_pkg::*;
#(
  parameter int unsigned C_NUM_REQ          = 2,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MAX_OUTSTANDING  = 8
) (
  input  logic                                    clk,
  input  logic                                    areset,
  input  logic [C_NUM_REQ-1:0]                    s_arvalid,
  output logic [C_NUM_REQ-1:0]                    s_arready,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [C_NUM_REQ*8-1:0]                  s_arlen,
  output logic [C_NUM_REQ-1:0]                    s_rvalid,
  input  logic [C_NUM_REQ-1:0]                    s_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           s_rdata,
  output logic                                    s_rlast,
  output logic                                    m_axi_arvalid,
  input  logic                                    m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                              m_axi_arlen,
  input  logic                                    m_axi_rvalid,
  output logic                                    m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic                                    m_axi_rlast,
  output logic [$clog2(C_MAX_OUTSTANDING):0]      outstanding,
  output logic                                    err_unexpected_r
`ifdef READ_ARB_PERF_CNT_EN
  ,
  input  logic                                    perf_clr,
  output logic [C_NUM_REQ*32-1:0]                 perf_beats
`endif
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;

  req_id_t         rr_ptr;
  req_id_t         grant;
  req_id_t         rr_next;
  req_id_t         head_id;
  logic            grant_found;
  logic            acc;
  logic            fifo_full;
  logic            fifo_empty;
  logic            head_rready;
  logic            r_pop;
  logic [AW-1:0]   sel_addr;
  logic [7:0]      sel_len;

  // Two passes: first valid at or above rr_ptr, otherwise wrap to the lowest valid.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
      if (!grant_found && s_arvalid[i] && (req_id_t'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant       = req_id_t'(i);
      end
    end
    for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
      if (!grant_found && s_arvalid[i]) begin
        grant_found = 1'b1;
        grant       = req_id_t'(i);
      end
    end
  end

  assign rr_next = (grant == req_id_t'(C_NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign acc     = grant_found && (!m_axi_arvalid || m_axi_arready) && !fifo_full;

  always_comb begin
    sel_addr    = '0;
    sel_len     = '0;
    head_rready = 1'b0;
    s_arready   = '0;
    s_rvalid    = '0;
    for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
      if (grant == req_id_t'(i)) begin
        sel_addr = s_araddr[i*AW +: AW];
        sel_len  = s_arlen[i*8 +: 8];
      end
      if (head_id == req_id_t'(i)) head_rready = s_rready[i];
      s_arready[i] = acc && (grant == req_id_t'(i));
      s_rvalid[i]  = m_axi_rvalid && !fifo_empty && (head_id == req_id_t'(i));
    end
  end

  assign m_axi_rready = !fifo_empty && head_rready;
  assign r_pop        = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign s_rdata      = m_axi_rdata;
  assign s_rlast      = m_axi_rlast;

  // The AR register reloads on the handshake cycle itself, allowing one AR per cycle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_axi_arvalid    <= 1'b0;
      m_axi_araddr     <= '0;
      m_axi_arlen      <= '0;
      rr_ptr           <= '0;
      err_unexpected_r <= 1'b0;
    end else begin
      if (acc) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= sel_addr;
        m_axi_arlen   <= sel_len;
        rr_ptr        <= rr_next;
      end else if (m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
      end
      if (m_axi_rvalid && fifo_empty) err_unexpected_r <= 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (C_MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .areset  (areset),
    .push    (acc),
    .push_id (grant),
    .pop     (r_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

`ifdef READ_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      perf_beats <= '0;
    end else if (perf_clr) begin
      perf_beats <= '0;
    end else begin
      for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
        if (s_rvalid[i] && s_rready[i]) perf_beats[i*32 +: 32] <= perf_beats[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_read_port_arbiter.sv
// Self-checking bench for read_port_arbiter: directed sequences, R-steering table, AR scoreboard.
module tb_read_port_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 64;
  localparam int unsigned MAXO = 8;

  logic                 clk = 1'b0;
  logic                 areset;
  logic [NREQ-1:0]      s_arvalid;
  logic [NREQ-1:0]      s_arready;
  logic [NREQ*AW-1:0]   s_araddr;
  logic [NREQ*8-1:0]    s_arlen;
  logic [NREQ-1:0]      s_rvalid;
  logic [NREQ-1:0]      s_rready;
  logic [DW-1:0]        s_rdata;
  logic                 s_rlast;
  logic                 m_axi_arvalid;
  logic                 m_axi_arready;
  logic [AW-1:0]        m_axi_araddr;
  logic [7:0]           m_axi_arlen;
  logic                 m_axi_rvalid;
  logic                 m_axi_rready;
  logic [DW-1:0]        m_axi_rdata;
  logic                 m_axi_rlast;
  logic [$clog2(MAXO):0] outstanding;
  logic                 err_unexpected_r;
`ifdef READ_ARB_PERF_CNT_EN
  logic                 perf_clr = 1'b0;
  logic [NREQ*32-1:0]   perf_beats;
`endif

  always #5 clk = ~clk;

  read_port_arbiter #(
    .C_NUM_REQ          (NREQ),
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_MAX_OUTSTANDING  (MAXO)
  ) dut (
    .clk              (clk),
    .areset           (areset),
    .s_arvalid        (s_arvalid),
    .s_arready        (s_arready),
    .s_araddr         (s_araddr),
    .s_arlen          (s_arlen),
    .s_rvalid         (s_rvalid),
    .s_rready         (s_rready),
    .s_rdata          (s_rdata),
    .s_rlast          (s_rlast),
    .m_axi_arvalid    (m_axi_arvalid),
    .m_axi_arready    (m_axi_arready),
    .m_axi_araddr     (m_axi_araddr),
    .m_axi_arlen      (m_axi_arlen),
    .m_axi_rvalid     (m_axi_rvalid),
    .m_axi_rready     (m_axi_rready),
    .m_axi_rdata      (m_axi_rdata),
    .m_axi_rlast      (m_axi_rlast),
    .outstanding      (outstanding),
    .err_unexpected_r (err_unexpected_r)
`ifdef READ_ARB_PERF_CNT_EN
    ,
    .perf_clr         (perf_clr),
    .perf_beats       (perf_beats)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_exp_t;

  typedef struct {
    logic          rv;
    logic [1:0]    rr;
    logic [DW-1:0] data;
    logic [1:0]    exp_sv;
    logic          exp_mr;
  } rvec_t;

  ar_exp_t    ar_q[$];
  logic [1:0] rtag_q[$];
  ar_exp_t    mon_e;
  rvec_t      tbl[7];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input int i, input logic [AW-1:0] addr, input logic [7:0] len);
    s_araddr[i*AW +: AW] = addr;
    s_arlen[i*8 +: 8]    = len;
  endtask

  task automatic expect_ar(input logic [1:0] req, input logic [AW-1:0] addr, input logic [7:0] len);
    ar_exp_t e;
    e.addr = addr;
    e.len  = len;
    ar_q.push_back(e);
    rtag_q.push_back(req);
  endtask

  task automatic do_reset();
    chk("ar_scoreboard_drained", 64'(ar_q.size()), 64'd0);
    s_arvalid     = '0;
    s_rready      = '1;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    areset        = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    ar_q.delete();
    rtag_q.delete();
  endtask

  // Returns every outstanding burst as a single last beat, in expected tag order.
  task automatic drain_all();
    logic [1:0] t;
    for (int i = 0; i < 16 && rtag_q.size() > 0; i++) begin
      t = rtag_q.pop_front();
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b1;
      s_rready     = '1;
      m_axi_rdata  = {$urandom, $urandom};
      #3;
      chk("drain_s_rvalid", 64'(s_rvalid), 64'(2'b01 << t));
      chk("drain_m_rready", 64'(m_axi_rready), 64'd1);
      chk("drain_rdata", s_rdata, m_axi_rdata);
      chk("drain_rlast", 64'(s_rlast), 64'd1);
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("drain_outstanding", 64'(outstanding), 64'd0);
  endtask

  // AR scoreboard: every handshake on the master AR channel must match the next expectation.
  always @(negedge clk) begin
    if (!areset && m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ar_unexpected: actual addr=%0h required no AR", m_axi_araddr);
      end else begin
        mon_e = ar_q.pop_front();
        chk("ar_addr", m_axi_araddr, mon_e.addr);
        chk("ar_len", 64'(m_axi_arlen), 64'(mon_e.len));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'b01, 64'h1111_0000_0000_0001, 2'b10, 1'b0};
    tbl[1] = '{1'b1, 2'b00, 64'h2222_0000_0000_0002, 2'b10, 1'b0};
    tbl[2] = '{1'b1, 2'b01, 64'h3333_0000_0000_0003, 2'b10, 1'b0};
    tbl[3] = '{1'b0, 2'b11, 64'h4444_0000_0000_0004, 2'b00, 1'b1};
    tbl[4] = '{1'b0, 2'b01, 64'h5555_0000_0000_0005, 2'b00, 1'b0};
    tbl[5] = '{1'b1, 2'b10, 64'h6666_0000_0000_0006, 2'b10, 1'b1};
    tbl[6] = '{1'b1, 2'b11, 64'h7777_0000_0000_0007, 2'b10, 1'b1};

    s_arvalid = '0;  s_araddr = '0;  s_arlen = '0;  s_rready = '1;
    m_axi_arready = 1'b1;  m_axi_rvalid = 1'b0;  m_axi_rlast = 1'b0;  m_axi_rdata = '0;
    areset = 1'b1;
    tick();
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    do_reset();
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
    chk("rst_err", 64'(err_unexpected_r), 64'd0);
    #3;
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_m_rready", 64'(m_axi_rready), 64'd0);
    tick();

    // Single requester, 4-beat burst
    s_arvalid = 2'b01;
    set_ar(0, 64'h1000, 8'd3);
    #3;
    chk("single_s_arready", 64'(s_arready), 64'b01);
    expect_ar(2'd0, 64'h1000, 8'd3);
    tick();
    s_arvalid = '0;
    chk("single_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("single_outstanding_1", 64'(outstanding), 64'd1);
    tick();
    void'(rtag_q.pop_front());
    for (int b = 0; b < 4; b++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (b == 3);
      m_axi_rdata  = 64'hA000 + 64'(b);
      #3;
      chk("single_s_rvalid", 64'(s_rvalid), 64'b01);
      chk("single_m_rready", 64'(m_axi_rready), 64'd1);
      chk("single_rdata", s_rdata, 64'hA000 + 64'(b));
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("single_outstanding_0", 64'(outstanding), 64'd0);

    // Fairness: both requesters hold valid, grants alternate starting at 0
    do_reset();
    s_arvalid = 2'b11;
    set_ar(0, 64'h2000, 8'd0);
    set_ar(1, 64'h3000, 8'd0);
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("fair_s_arready", 64'(s_arready), (c % 2 == 0) ? 64'b01 : 64'b10);
      if (c % 2 == 0) expect_ar(2'd0, 64'h2000, 8'd0);
      else            expect_ar(2'd1, 64'h3000, 8'd0);
      tick();
    end
    s_arvalid = '0;
    chk("fair_outstanding", 64'(outstanding), 64'd4);
    drain_all();

    // Full: exactly MAXO accepted, a same-cycle pop does not unblock
    do_reset();
    s_arvalid = 2'b01;
    set_ar(0, 64'h4000, 8'd0);
    for (int c = 0; c < 10; c++) begin
      #3;
      chk("full_s_arready", 64'(s_arready), (c < 8) ? 64'b01 : 64'b00);
      if (c < 8) expect_ar(2'd0, 64'h4000, 8'd0);
      tick();
    end
    chk("full_outstanding", 64'(outstanding), 64'd8);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    #3;
    chk("full_pop_cycle_s_arready", 64'(s_arready), 64'd0);
    chk("full_pop_cycle_m_rready", 64'(m_axi_rready), 64'd1);
    tick();
    void'(rtag_q.pop_front());
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    #3;
    chk("full_ninth_s_arready", 64'(s_arready), 64'b01);
    expect_ar(2'd0, 64'h4000, 8'd0);
    tick();
    s_arvalid = '0;
    chk("full_outstanding_again", 64'(outstanding), 64'd8);
    drain_all();

    // AR stall: master AR held stable while arready is low
    s_arvalid = 2'b10;
    set_ar(1, 64'h5000, 8'd7);
    #3;
    chk("stall_first_s_arready", 64'(s_arready), 64'b10);
    expect_ar(2'd1, 64'h5000, 8'd7);
    tick();
    m_axi_arready = 1'b0;
    s_arvalid     = 2'b11;
    set_ar(0, 64'h6000, 8'd2);
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("stall_s_arready", 64'(s_arready), 64'd0);
      chk("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("stall_araddr", m_axi_araddr, 64'h5000);
      chk("stall_arlen", 64'(m_axi_arlen), 64'd7);
      tick();
    end
    m_axi_arready = 1'b1;
    #3;
    chk("stall_release_s_arready", 64'(s_arready), 64'b01);
    expect_ar(2'd0, 64'h6000, 8'd2);
    tick();
    s_arvalid = '0;
    chk("stall_reload_araddr", m_axi_araddr, 64'h6000);
    tick();

    // R ordering / backpressure: req1 burst then req0 burst, steering table
    do_reset();
    s_arvalid = 2'b10;
    set_ar(1, 64'h7000, 8'd3);
    #3;
    chk("order_s_arready_1", 64'(s_arready), 64'b10);
    expect_ar(2'd1, 64'h7000, 8'd3);
    tick();
    s_arvalid = 2'b01;
    set_ar(0, 64'h8000, 8'd0);
    #3;
    chk("order_s_arready_0", 64'(s_arready), 64'b01);
    expect_ar(2'd0, 64'h8000, 8'd0);
    tick();
    s_arvalid = '0;
    chk("order_outstanding", 64'(outstanding), 64'd2);
    for (int j = 0; j < 7; j++) begin
      m_axi_rvalid = tbl[j].rv;
      s_rready     = tbl[j].rr;
      m_axi_rlast  = 1'b0;
      m_axi_rdata  = tbl[j].data;
      #3;
      chk("tbl_s_rvalid", 64'(s_rvalid), 64'(tbl[j].exp_sv));
      chk("tbl_m_rready", 64'(m_axi_rready), 64'(tbl[j].exp_mr));
      chk("tbl_rdata", s_rdata, tbl[j].data);
      tick();
    end
    chk("order_outstanding_held", 64'(outstanding), 64'd2);
    drain_all();

    // Unexpected R beat with nothing outstanding, then reset mid-burst
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    #3;
    chk("err_m_rready", 64'(m_axi_rready), 64'd0);
    chk("err_s_rvalid", 64'(s_rvalid), 64'd0);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("err_set", 64'(err_unexpected_r), 64'd1);
    tick();
    chk("err_sticky", 64'(err_unexpected_r), 64'd1);
    m_axi_arready = 1'b0;
    s_arvalid     = 2'b01;
    set_ar(0, 64'h9000, 8'd3);
    #3;
    chk("midrst_s_arready", 64'(s_arready), 64'b01);
    tick();
    s_arvalid = '0;
    chk("midrst_arvalid_pre", 64'(m_axi_arvalid), 64'd1);
    chk("midrst_outstanding_pre", 64'(outstanding), 64'd1);
    m_axi_rvalid = 1'b1;
    #3;
    chk("midrst_beat_s_rvalid", 64'(s_rvalid), 64'b01);
    tick();
    m_axi_rvalid = 1'b0;
    areset = 1'b1;
    #1;
    chk("midrst_err", 64'(err_unexpected_r), 64'd0);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("midrst_araddr", m_axi_araddr, 64'd0);
    tick();
    areset        = 1'b0;
    m_axi_arready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_port_arbiter.md
# read_port_arbiter

Shares one AXI4 read-only master port between `C_NUM_REQ` independent read masters (NFA loader, query reader, future result/config readers) so they can run concurrently instead of being time-multiplexed by a state machine. Address requests are granted round-robin through a one-stage AR output register. Each granted requester index is pushed into an in-order tag FIFO, and R beats are steered back to the requester at the FIFO head. The block sits between the per-stream `*_axi_read_master` instances and the kernel's `m_axi` read port.

## Interface
Parameters:
- `C_NUM_REQ`, 2: number of requesters; range 2..4.
- `C_M_AXI_ADDR_WIDTH`, 64: address width.
- `C_M_AXI_DATA_WIDTH`, 512: data width.
- `C_MAX_OUTSTANDING`, 8: maximum in-flight bursts; tag FIFO depth; power of 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_arvalid`  in  `C_NUM_REQ`  per-requester AR valid.
- `s_arready`  out  `C_NUM_REQ`  per-requester AR accept; at most one bit high per cycle.
- `s_araddr`  in  `C_NUM_REQ*C_M_AXI_ADDR_WIDTH`  packed addresses; requester i at slice i.
- `s_arlen`  in  `C_NUM_REQ*8`  packed burst lengths.
- `s_rvalid`  out  `C_NUM_REQ`  per-requester R valid.
- `s_rready`  in  `C_NUM_REQ`  per-requester R ready.
- `s_rdata`  out  `C_M_AXI_DATA_WIDTH`  broadcast R data.
- `s_rlast`  out  1  broadcast R last.
- `m_axi_arvalid`, `m_axi_arready`, `m_axi_araddr`, `m_axi_arlen`: AXI4 AR channel, master side.
- `m_axi_rvalid`, `m_axi_rready`, `m_axi_rdata`, `m_axi_rlast`: AXI4 R channel, master side.
- `outstanding`  out  `$clog2(C_MAX_OUTSTANDING)+1`  number of in-flight bursts.
- `err_unexpected_r`  out  1  sticky flag; set on an R beat arriving while no burst is outstanding.

## Operation
- **Accept condition:** `acc = any(s_arvalid) && (!m_axi_arvalid || m_axi_arready) && outstanding < C_MAX_OUTSTANDING`.
- **Arbitration:** round-robin over `s_arvalid`, starting at priority pointer `rr_ptr`. On `acc`, the winner `g` gets `s_arready[g]=1` (combinational). `s_araddr[g]` and `s_arlen[g]` load into the AR output register, `m_axi_arvalid` is set, `g` is pushed into the tag FIFO, and `rr_ptr` becomes `(g+1) mod C_NUM_REQ`.
- **AR stability:** `m_axi_arvalid`, `m_axi_araddr` and `m_axi_arlen` hold until `m_axi_arready`. The register is reloaded on the same cycle as the handshake when `acc` holds, so back-to-back issue of one AR per cycle is supported.
- **R steering:** with `head` the FIFO head and `ne` = FIFO not empty:
  - `s_rvalid[i] = m_axi_rvalid && ne && head==i`
  - `m_axi_rready = ne && s_rready[head]`
  - `s_rdata`/`s_rlast` = `m_axi_rdata`/`m_axi_rlast` unmodified.
- **Pop:** the FIFO pops on `m_axi_rvalid && m_axi_rready && m_axi_rlast`.
- **`outstanding`:** +1 on push, -1 on pop, unchanged when push and pop coincide.
- **Empty FIFO with `m_axi_rvalid=1`:** `m_axi_rready` stays 0, `err_unexpected_r` is set and stays set until reset.
- **Full (`outstanding == C_MAX_OUTSTANDING`):** all `s_arready` are 0. A pop in the same cycle does not unblock; acceptance resumes the next cycle.

## Timing
- **Reset values:** `m_axi_arvalid=0`, `m_axi_araddr=0`, `m_axi_arlen=0`, `rr_ptr=0`, FIFO empty, `outstanding=0`, `err_unexpected_r=0`. Derived outputs: `s_arready=0`, `s_rvalid=0`, `m_axi_rready=0`.
- **Latency:** AR is 1 cycle (`s_arvalid` accept at cycle n gives `m_axi_arvalid` at n+1). R path is 0 cycles, combinational.
- **Throughput:** 1 AR per cycle; 1 R beat per cycle.
- **Reset mid-operation:** `areset` clears everything immediately. In-flight bursts are abandoned; any later R beats raise `err_unexpected_r`. The system resets the memory side at the same time.

## Configuration
- **`READ_ARB_PERF_CNT_EN`:** when defined, adds output `perf_beats` (`C_NUM_REQ*32`) and input `perf_clr`.
  - `perf_beats` holds per-requester 32-bit R-beat handshake counters. They wrap at 2^32, reset to 0, and clear synchronously on `perf_clr`; `perf_clr` wins over a same-cycle increment.
  - When undefined, neither port nor the counters exist, and behaviour is otherwise identical.

## Structure
- **Shared package `read_arb_pkg`:** requester-id typedef (`logic [1:0]`), index constants `REQ_NFA=0`, `REQ_QUERY=1`, and the `C_MAX_REQ=4` limit.
- **Sub-module `tag_fifo`:** synchronous FIFO with depth `C_MAX_OUTSTANDING`, id-width entries, simultaneous push/pop, and full/empty/count outputs.
- **Top level:** round-robin arbiter, AR register and R steering.

## Test plan
- **Single requester:** req0 issues `araddr=0x1000, arlen=3` with `m_axi_arready=1`. Expect `m_axi_arvalid` 1 cycle later with the same fields, 4 beats delivered only on `s_rvalid[0]`, and `outstanding` going 0→1→0.
- **Fairness:** req0 and req1 hold `s_arvalid` continuously. Grants alternate 0,1,0,1 starting with 0 after reset, one AR per cycle.
- **Backpressure/full:** `C_MAX_OUTSTANDING=8`, `m_axi_arready=1`, no R returned. Exactly 8 ARs are accepted and `s_arready` stays 0. One rlast arrives; the 9th AR is accepted on the following cycle.
- **AR stall:** `m_axi_arready=0` for 5 cycles. `m_axi_araddr`/`m_axi_arlen` stay stable and no further `s_arready` is issued until the handshake.
- **R ordering/backpressure:** bursts for req1 then req0 are issued. Hold `s_rready[1]=0` for 3 cycles; `m_axi_rready` stays 0 and req0 receives nothing until req1's burst completes.
- **Error and reset:** `m_axi_rvalid=1` with the FIFO empty gives `err_unexpected_r=1` and `m_axi_rready=0`. Asserting `areset` mid-burst clears the flag, `outstanding` and `m_axi_arvalid` immediately.
